// File: rtl/decode_writeback.sv
// ----------------------------------------------------------------------------
// decode_writeback
//   Y86-64 SEQ decode / write-back stage. It derives the register sources and
//   destinations from icode/rA/rB/cnd. It holds the 15 x WORD register file,
//   drives operands valA/valB to execute, and commits valE/valM on the clock.
//
//   Optional feature macro: REGFILE_BYPASS_EN
//     When this macro is defined, a read of a register that is being written
//     this cycle returns the write data. M has priority over E, and E has
//     priority over the stored value. This applies to valA, valB and dbg_data.
//     It is meant for pipelined integration only, because in SEQ it creates a
//     combinational loop through execute. When the macro is undefined, reads
//     return the pre-edge contents of the register.
//
//   Ports
//     clk, reset      rising-edge clock, synchronous active-high reset
//     icode, rA, rB   instruction fields from fetch
//     cnd             execute condition (gates the cmovXX destination)
//     w_dstE/w_valE   write port E (id 0xF = no write)
//     w_dstM/w_valM   write port M (id 0xF = no write)
//     wb_en           global write enable for this cycle
//     dbg_addr        debug read select
//     valA, valB      operands to execute
//     dstE, dstM      derived destinations (looped back by the SEQ top)
//     dbg_data        R[dbg_addr], or 0 for id 0xF
// ----------------------------------------------------------------------------
module decode_writeback #(
  parameter int unsigned WORD   = 64,
  parameter int unsigned NREGS  = 15,
  parameter int unsigned RSP_ID = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      icode,
  input  logic [3:0]      rA,
  input  logic [3:0]      rB,
  input  logic            cnd,
  input  logic [3:0]      w_dstE,
  input  logic [WORD-1:0] w_valE,
  input  logic [3:0]      w_dstM,
  input  logic [WORD-1:0] w_valM,
  input  logic            wb_en,
  input  logic [3:0]      dbg_addr,
  output logic [WORD-1:0] valA,
  output logic [WORD-1:0] valB,
  output logic [3:0]      dstE,
  output logic [3:0]      dstM,
  output logic [WORD-1:0] dbg_data
);

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = RSP_ID[3:0];

  logic [WORD-1:0] regs [NREGS];
  logic [3:0]      srcA, srcB;

  // Source and destination select
  always_comb begin
    srcA = RNONE;
    srcB = RNONE;
    dstE = RNONE;
    dstM = RNONE;
    case (icode_e'(icode))
      I_RRMOVQ: begin
        srcA = rA;
        dstE = cnd ? rB : RNONE;
      end
      I_IRMOVQ: dstE = rB;
      I_RMMOVQ: begin
        srcA = rA;
        srcB = rB;
      end
      I_MRMOVQ: begin
        srcB = rB;
        dstM = rA;
      end
      I_OPQ: begin
        srcA = rA;
        srcB = rB;
        dstE = rB;
      end
      I_CALL: begin
        srcB = RSP;
        dstE = RSP;
      end
      I_RET: begin
        srcA = RSP;
        srcB = RSP;
        dstE = RSP;
      end
      I_PUSHQ: begin
        srcA = rA;
        srcB = RSP;
        dstE = RSP;
      end
      I_POPQ: begin
        srcA = RSP;
        srcB = RSP;
        dstE = RSP;
        dstM = rA;
      end
      default: ;
    endcase
  end

  // Register read with an optional same-cycle forward of the write data
  function automatic logic [WORD-1:0] read_reg(
    input logic [3:0]      id,
    input logic [WORD-1:0] stored
  );
    logic [WORD-1:0] r;
    r = (id != RNONE) ? stored : '0;
`ifdef REGFILE_BYPASS_EN
    if (wb_en && id != RNONE) begin
      if (w_dstM == id)      r = w_valM;
      else if (w_dstE == id) r = w_valE;
    end
`endif
    return r;
  endfunction

  logic [WORD-1:0] stored_a, stored_b, stored_d;

  always_comb begin
    stored_a = '0;
    stored_b = '0;
    stored_d = '0;
    if (int'(srcA) < int'(NREGS))     stored_a = regs[srcA];
    if (int'(srcB) < int'(NREGS))     stored_b = regs[srcB];
    if (int'(dbg_addr) < int'(NREGS)) stored_d = regs[dbg_addr];
    valA     = read_reg(srcA, stored_a);
    valB     = read_reg(srcB, stored_b);
    dbg_data = read_reg(dbg_addr, stored_d);
  end

  // Write-back. The M write is issued after the E write, so it wins when both
  // ports target the same register (popq %rsp).
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_en) begin
      if (w_dstE != RNONE && int'(w_dstE) < int'(NREGS)) regs[w_dstE] <= w_valE;
      if (w_dstM != RNONE && int'(w_dstM) < int'(NREGS)) regs[w_dstM] <= w_valM;
    end
  end

endmodule

// File: tb/tb_decode_writeback.sv
// ----------------------------------------------------------------------------
// tb_decode_writeback
//   Directed bench for decode_writeback: reset state, operand and destination
//   decode, write-back, dual-port priority, reset override and the optional
//   same-cycle bypass (REGFILE_BYPASS_EN).
// ----------------------------------------------------------------------------
module tb_decode_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  icode, rA, rB;
  logic        cnd;
  logic [3:0]  w_dstE, w_dstM;
  logic [63:0] w_valE, w_valM;
  logic        wb_en;
  logic [3:0]  dbg_addr;
  logic [63:0] valA, valB, dbg_data;
  logic [3:0]  dstE, dstM;

  int compared   = 0;
  int mismatched = 0;

  decode_writeback #(.WORD(64), .NREGS(15), .RSP_ID(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .icode    (icode),
    .rA       (rA),
    .rB       (rB),
    .cnd      (cnd),
    .w_dstE   (w_dstE),
    .w_valE   (w_valE),
    .w_dstM   (w_dstM),
    .w_valM   (w_valM),
    .wb_en    (wb_en),
    .dbg_addr (dbg_addr),
    .valA     (valA),
    .valB     (valB),
    .dstE     (dstE),
    .dstM     (dstM),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic no_write();
    wb_en  = 1'b0;
    w_dstE = 4'hF;
    w_dstM = 4'hF;
    w_valE = '0;
    w_valM = '0;
  endtask

  task automatic write_e(input logic [3:0] id, input logic [63:0] v);
    wb_en  = 1'b1;
    w_dstE = id;
    w_valE = v;
    w_dstM = 4'hF;
    tick();
    no_write();
  endtask

  initial begin
    reset = 1'b1; icode = 4'h0; rA = 4'hF; rB = 4'hF; cnd = 1'b0;
    dbg_addr = 4'hF;
    no_write();
    tick();
    reset = 1'b0;

    // 1: reset state and OPq decode
    icode = 4'h6; rA = 4'h2; rB = 4'h3; #1;
    check("rst_valA", valA, 64'd0);
    check("rst_valB", valB, 64'd0);
    check("opq_dstE", {60'd0, dstE}, 64'h3);
    check("opq_dstM", {60'd0, dstM}, 64'hF);
    check("rst_dbgF", dbg_data, 64'd0);

    // 2: writes and wb_en gating
    write_e(4'h2, 64'd10);
    write_e(4'h3, 64'd50);
    #1;
    check("wr_valA", valA, 64'd10);
    check("wr_valB", valB, 64'd50);
    wb_en = 1'b0; w_dstE = 4'h2; w_valE = 64'd99;
    tick();
    no_write(); #1;
    check("hold_valA", valA, 64'd10);
    dbg_addr = 4'h2; #1;
    check("hold_dbg2", dbg_data, 64'd10);

    // 3: cmov gating and other decodes
    icode = 4'h2; rA = 4'h1; rB = 4'h5; cnd = 1'b0; #1;
    check("cmov0_dstE", {60'd0, dstE}, 64'hF);
    cnd = 1'b1; #1;
    check("cmov1_dstE", {60'd0, dstE}, 64'h5);
    check("cmov_dstM", {60'd0, dstM}, 64'hF);
    rA = 4'h2; #1;
    check("cmov_valA", valA, 64'd10);
    check("cmov_valB", valB, 64'd0);
    icode = 4'h7; rA = 4'h1; rB = 4'h5; #1;
    check("jxx_dstE", {60'd0, dstE}, 64'hF);
    check("jxx_dstM", {60'd0, dstM}, 64'hF);
    rA = 4'h2; rB = 4'h3; #1;
    check("jxx_valA", valA, 64'd0);
    check("jxx_valB", valB, 64'd0);
    icode = 4'hC; #1;
    check("undef_dstE", {60'd0, dstE}, 64'hF);
    check("undef_valA", valA, 64'd0);
    icode = 4'h3; rA = 4'hF; rB = 4'h3; #1;
    check("irm_dstE", {60'd0, dstE}, 64'h3);
    check("irm_valB", valB, 64'd0);
    icode = 4'h5; rA = 4'h2; rB = 4'h3; #1;
    check("mrm_dstM", {60'd0, dstM}, 64'h2);
    check("mrm_dstE", {60'd0, dstE}, 64'hF);
    check("mrm_valA", valA, 64'd0);
    check("mrm_valB", valB, 64'd50);
    icode = 4'h4; #1;
    check("rmm_valA", valA, 64'd10);
    check("rmm_dstE", {60'd0, dstE}, 64'hF);

    // 4: popq %rsp -- M wins over E
    wb_en = 1'b1; w_dstE = 4'h4; w_valE = 64'h108; w_dstM = 4'h4; w_valM = 64'h55;
    tick();
    no_write();
    dbg_addr = 4'h4; #1;
    check("pop_dbg4", dbg_data, 64'h55);
    icode = 4'hB; rA = 4'h4; rB = 4'hF; #1;
    check("pop_dstM", {60'd0, dstM}, 64'h4);
    check("pop_dstE", {60'd0, dstE}, 64'h4);
    check("pop_valA", valA, 64'h55);
    check("pop_valB", valB, 64'h55);
    icode = 4'h8; #1;
    check("call_dstE", {60'd0, dstE}, 64'h4);
    check("call_valA", valA, 64'd0);
    check("call_valB", valB, 64'h55);
    // Dual write to distinct registers, and a write to id F is ignored.
    wb_en = 1'b1; w_dstE = 4'h5; w_valE = 64'hFFFF_FFFF_FFFF_FFFB;
    w_dstM = 4'h6; w_valM = 64'h6;
    tick();
    no_write();
    dbg_addr = 4'h5; #1;
    check("dual_dbg5", dbg_data, 64'hFFFF_FFFF_FFFF_FFFB);
    dbg_addr = 4'h6; #1;
    check("dual_dbg6", dbg_data, 64'h6);
    write_e(4'hF, 64'h1234);
    dbg_addr = 4'hF; #1;
    check("rnone_dbg", dbg_data, 64'd0);
    dbg_addr = 4'hE; #1;
    check("rnone_r14", dbg_data, 64'd0);

    // 5: reset overrides a pending write
    write_e(4'h7, 64'hDEAD);
    dbg_addr = 4'h7; #1;
    check("pre_rst_r7", dbg_data, 64'hDEAD);
    reset = 1'b1; wb_en = 1'b1; w_dstE = 4'h7; w_valE = 64'd1;
    tick();
    reset = 1'b0;
    no_write(); #1;
    check("rst_r7", dbg_data, 64'd0);
    for (int i = 0; i < 15; i++) begin
      dbg_addr = 4'(i); #1;
      check($sformatf("rst_r%0d", i), dbg_data, 64'd0);
    end

    // 6: same-cycle read of a register being written
    write_e(4'h2, 64'd10);
    icode = 4'h6; rA = 4'h2; rB = 4'h3; dbg_addr = 4'h2;
    wb_en = 1'b1; w_dstE = 4'h2; w_valE = 64'd77; #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_valA", valA, 64'd77);
    check("byp_dbg2", dbg_data, 64'd77);
    w_dstM = 4'h2; w_valM = 64'd88; #1;
    check("byp_m_over_e", valA, 64'd88);
    w_dstM = 4'hF; #1;
`else
    check("nobyp_valA", valA, 64'd10);
    check("nobyp_dbg2", dbg_data, 64'd10);
`endif
    tick();
    no_write(); #1;
    check("post_valA", valA, 64'd77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
